// File: rtl/ok_wire_pkg.sv
// -----------------------------------------------------------------------------
// ok_wire_pkg
//
// Purpose : Shared constants and small helpers for the wire-in bank
//           (ok_wire_bank / ok_wire_chan). It holds the host word width,
//           the endpoint address width, the legal wire-in address window
//           and the channel-width limits.
//
// Contents:
//   WORD_W        host data word width (16)
//   ADDR_W        host endpoint address width (8)
//   WIRE_IN_MIN   lowest legal wire-in endpoint address
//   WIRE_IN_MAX   highest legal wire-in endpoint address
//   MIN_CH_WIDTH  / MAX_CH_WIDTH  channel width limits
//   MAX_NUM_CH    maximum channel count
//   word_t, addr_t             convenience typedefs
//   word_addr()                endpoint address of channel/word
//   bank_cfg_ok()              parameter legality check
// -----------------------------------------------------------------------------
package ok_wire_pkg;

    localparam int WORD_W       = 16;
    localparam int ADDR_W       = 8;
    localparam int MIN_CH_WIDTH = 16;
    localparam int MAX_CH_WIDTH = 64;
    localparam int MAX_NUM_CH   = 32;

    localparam logic [ADDR_W-1:0] WIRE_IN_MIN = 8'h00;
    localparam logic [ADDR_W-1:0] WIRE_IN_MAX = 8'h1F;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Endpoint address of word w of channel ch. Words are laid out channel
    // by channel, least significant word first.
    function automatic addr_t word_addr(input int base, input int ch,
                                        input int words, input int w);
        return addr_t'(base + ch * words + w);
    endfunction

    // True when the bank parameters form a legal configuration: channel
    // count and width in range, width a whole number of words, and the
    // whole bank inside the wire-in address window.
    function automatic bit bank_cfg_ok(input int base, input int num_ch,
                                       input int ch_width);
        int last_addr;
        bit ok;
        ok = 1'b1;
        if (num_ch < 1 || num_ch > MAX_NUM_CH) begin
            ok = 1'b0;
        end
        if (ch_width < MIN_CH_WIDTH || ch_width > MAX_CH_WIDTH) begin
            ok = 1'b0;
        end
        if ((ch_width % WORD_W) != 0) begin
            ok = 1'b0;
        end
        last_addr = base + num_ch * (ch_width / WORD_W) - 1;
        if (base < int'(WIRE_IN_MIN) || last_addr > int'(WIRE_IN_MAX)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ok_wire_chan.sv
// -----------------------------------------------------------------------------
// ok_wire_chan
//
// Purpose : One wire-in channel. Holds CH_WIDTH/16 host words written over
//           the 16-bit host bus, and copies them into the committed output
//           register when the bank commit strobe fires. Tracks whether the
//           channel was written since the last commit, and pulses a change
//           flag the cycle after a commit that altered the committed value.
//
// Parameters:
//   CH_WIDTH   channel width in bits (multiple of 16)
//   CH_ADDR    endpoint address of this channel's least significant word
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   write_i      host write strobe
//   addr_i       host endpoint address
//   datain_i     host write data
//   commit_i     commit strobe (shared by all channels)
//   data_o       committed channel value
//   changed_o    one-cycle pulse: last commit changed data_o
//   pending_o    channel written since last commit
//   hold_o       hold-register contents (only with OK_WIRE_READBACK_EN)
//
// Configuration macro: OK_WIRE_READBACK_EN adds hold_o for host readback.
// -----------------------------------------------------------------------------
module ok_wire_chan
    import ok_wire_pkg::*;
#(
    parameter int    CH_WIDTH = 32,
    parameter addr_t CH_ADDR  = 8'h00
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                write_i,
    input  addr_t               addr_i,
    input  word_t               datain_i,
    input  logic                commit_i,
    output logic [CH_WIDTH-1:0] data_o,
    output logic                changed_o,
`ifdef OK_WIRE_READBACK_EN
    output logic [CH_WIDTH-1:0] hold_o,
`endif
    output logic                pending_o
);

    localparam int WORDS = CH_WIDTH / WORD_W;

    logic [WORDS-1:0][WORD_W-1:0] hold_q, hold_d;
    logic [CH_WIDTH-1:0]          data_q, data_d;
    logic                         changed_q, changed_d;
    logic                         pending_q, pending_d;
    logic                         write_hit;

    always_comb begin
        hold_d    = hold_q;
        write_hit = 1'b0;
        for (int w = 0; w < WORDS; w++) begin
            if (write_i && (addr_i == addr_t'(int'(CH_ADDR) + w))) begin
                hold_d[w] = datain_i;
                write_hit = 1'b1;
            end
        end

        data_d    = data_q;
        changed_d = 1'b0;
        pending_d = pending_q | write_hit;

        // The commit takes hold_d rather than hold_q so a write landing in
        // the same cycle is part of this commit; for the same reason the
        // pending flag ends up clear rather than set by that write.
        if (commit_i) begin
            data_d    = hold_d;
            changed_d = (hold_d != data_q);
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q    <= '0;
            data_q    <= '0;
            changed_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            data_q    <= data_d;
            changed_q <= changed_d;
            pending_q <= pending_d;
        end
    end

    assign data_o    = data_q;
    assign changed_o = changed_q;
    assign pending_o = pending_q;
`ifdef OK_WIRE_READBACK_EN
    assign hold_o    = hold_q;
`endif

endmodule

// File: rtl/ok_wire_bank.sv
// -----------------------------------------------------------------------------
// ok_wire_bank
//
// Purpose : Bank of NUM_CH wire-in channels, each CH_WIDTH bits wide, written
//           16 bits at a time over the host bus and committed atomically by
//           ti_wireupdate. Channel i word w lives at BASE_ADDR + i*WORDS + w.
//
// Host bus semantics: ti_write is a single-cycle strobe qualified only by
// ti_addr; there is no back-pressure, every strobe is accepted at the edge
// where it is high. ti_wireupdate commits all channels at that same edge,
// after any write of that cycle has been applied to the hold registers.
//
// Parameters:
//   BASE_ADDR  first endpoint address of the bank
//   NUM_CH     number of channels (1..32)
//   CH_WIDTH   bits per channel (16..64, multiple of 16)
//
// Ports:
//   ti_clock       clock, rising edge
//   ti_reset_n     synchronous active-low reset
//   ti_write       host write strobe
//   ti_addr        host endpoint address
//   ti_datain      host write data
//   ti_wireupdate  commit strobe
//   ti_read        host read strobe        (OK_WIRE_READBACK_EN only)
//   ti_dataout     host read data, 1 cycle (OK_WIRE_READBACK_EN only)
//   ep_dataout     committed values, channel i at [i*CH_WIDTH +: CH_WIDTH]
//   ep_changed     per-channel one-cycle change pulse after a commit
//   ep_pending     channel written since last commit
//   ep_updated     one-cycle pulse after every commit
//
// Configuration macro: OK_WIRE_READBACK_EN enables host readback of the
// hold registers.
// -----------------------------------------------------------------------------
module ok_wire_bank
    import ok_wire_pkg::*;
#(
    parameter addr_t BASE_ADDR = 8'h00,
    parameter int    NUM_CH    = 4,
    parameter int    CH_WIDTH  = 32
) (
    input  logic                       ti_clock,
    input  logic                       ti_reset_n,
    input  logic                       ti_write,
    input  addr_t                      ti_addr,
    input  word_t                      ti_datain,
    input  logic                       ti_wireupdate,
`ifdef OK_WIRE_READBACK_EN
    input  logic                       ti_read,
    output word_t                      ti_dataout,
`endif
    output logic [NUM_CH*CH_WIDTH-1:0] ep_dataout,
    output logic [NUM_CH-1:0]          ep_changed,
    output logic [NUM_CH-1:0]          ep_pending,
    output logic                       ep_updated
);

    localparam int WORDS = CH_WIDTH / WORD_W;

    // Reject illegal configurations at elaboration time.
    if (!bank_cfg_ok(int'(BASE_ADDR), NUM_CH, CH_WIDTH)) begin : g_bad_cfg
        $fatal(1, "ok_wire_bank: illegal parameters (BASE_ADDR/NUM_CH/CH_WIDTH)");
    end

    logic updated_q, updated_d;

`ifdef OK_WIRE_READBACK_EN
    logic [NUM_CH*CH_WIDTH-1:0] hold_flat;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        ok_wire_chan #(
            .CH_WIDTH (CH_WIDTH),
            .CH_ADDR  (word_addr(int'(BASE_ADDR), ch, WORDS, 0))
        ) u_chan (
            .clk_i     (ti_clock),
            .rst_ni    (ti_reset_n),
            .write_i   (ti_write),
            .addr_i    (ti_addr),
            .datain_i  (ti_datain),
            .commit_i  (ti_wireupdate),
            .data_o    (ep_dataout[ch*CH_WIDTH +: CH_WIDTH]),
            .changed_o (ep_changed[ch]),
`ifdef OK_WIRE_READBACK_EN
            .hold_o    (hold_flat[ch*CH_WIDTH +: CH_WIDTH]),
`endif
            .pending_o (ep_pending[ch])
        );
    end

    // Commit acknowledge: one pulse per commit, so consecutive commits give
    // consecutive pulses.
    assign updated_d = ti_wireupdate;

    always_ff @(posedge ti_clock) begin
        if (!ti_reset_n) begin
            updated_q <= 1'b0;
        end else begin
            updated_q <= updated_d;
        end
    end

    assign ep_updated = updated_q;

`ifdef OK_WIRE_READBACK_EN
    word_t rd_data_q, rd_data_d;

    // Words are packed channel by channel, least significant first, so the
    // bank-relative address k is simply word k of hold_flat.
    always_comb begin
        rd_data_d = '0;
        if (ti_read) begin
            for (int k = 0; k < NUM_CH * WORDS; k++) begin
                if (ti_addr == addr_t'(int'(BASE_ADDR) + k)) begin
                    rd_data_d = hold_flat[k*WORD_W +: WORD_W];
                end
            end
        end
    end

    always_ff @(posedge ti_clock) begin
        if (!ti_reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign ti_dataout = rd_data_q;
`endif

endmodule

// File: tb/tb_ok_wire_bank.sv
// -----------------------------------------------------------------------------
// tb_ok_wire_bank
//
// Directed bench for ok_wire_bank with BASE_ADDR=8'h04, NUM_CH=4,
// CH_WIDTH=32 (channel i at addresses 04+2i, 05+2i). Each commit pushes the
// hand-computed committed value and change mask; a monitor pops and compares
// them whenever ep_updated is seen.
// Build with OK_WIRE_READBACK_EN to include the readback section.
// -----------------------------------------------------------------------------
module tb_ok_wire_bank;
    import ok_wire_pkg::*;

    localparam int    NUM_CH   = 4;
    localparam int    CH_WIDTH = 32;
    localparam addr_t BASE     = 8'h04;
    localparam int    DW       = NUM_CH * CH_WIDTH;

    // ---------------- clock / reset ----------------
    logic              ti_clock      = 1'b0;
    logic              ti_reset_n    = 1'b0;
    logic              ti_write      = 1'b0;
    addr_t             ti_addr       = '0;
    word_t             ti_datain     = '0;
    logic              ti_wireupdate = 1'b0;
`ifdef OK_WIRE_READBACK_EN
    logic              ti_read       = 1'b0;
    word_t             ti_dataout;
`endif
    logic [DW-1:0]     ep_dataout;
    logic [NUM_CH-1:0] ep_changed;
    logic [NUM_CH-1:0] ep_pending;
    logic              ep_updated;

    always #5 ti_clock = ~ti_clock;

    ok_wire_bank #(
        .BASE_ADDR (BASE),
        .NUM_CH    (NUM_CH),
        .CH_WIDTH  (CH_WIDTH)
    ) dut (
        .ti_clock      (ti_clock),
        .ti_reset_n    (ti_reset_n),
        .ti_write      (ti_write),
        .ti_addr       (ti_addr),
        .ti_datain     (ti_datain),
        .ti_wireupdate (ti_wireupdate),
`ifdef OK_WIRE_READBACK_EN
        .ti_read       (ti_read),
        .ti_dataout    (ti_dataout),
`endif
        .ep_dataout    (ep_dataout),
        .ep_changed    (ep_changed),
        .ep_pending    (ep_pending),
        .ep_updated    (ep_updated)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]     exp_q[$];
    logic [NUM_CH-1:0] exp_chg_q[$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: runs on the falling edge, away from the updating edge.
    always @(negedge ti_clock) begin
        logic [DW-1:0]     e_data;
        logic [NUM_CH-1:0] e_chg;
        if (ep_updated === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_update: ep_updated=1 with no commit outstanding");
            end else begin
                e_data = exp_q.pop_front();
                e_chg  = exp_chg_q.pop_front();
                check("commit_dataout", ep_dataout, e_data);
                check("commit_changed", DW'(ep_changed), DW'(e_chg));
                check("commit_pending_clear", DW'(ep_pending), '0);
            end
        end else begin
            check("changed_without_update", DW'(ep_changed), '0);
        end
    end

    // ---------------- driver tasks ----------------
    // Each step waits for a falling edge, then drives one cycle of inputs.
    // Outputs observed right after a step reflect the previous step.
    task automatic step(input logic rst_n, input logic wr, input addr_t addr,
                        input word_t data, input logic upd, input logic rd);
        @(negedge ti_clock);
        ti_reset_n    = rst_n;
        ti_write      = wr;
        ti_addr       = addr;
        ti_datain     = data;
        ti_wireupdate = upd;
`ifdef OK_WIRE_READBACK_EN
        ti_read       = rd;
`else
        if (rd) begin
            $display("note: read requested without readback build");
        end
`endif
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic wr(input addr_t addr, input word_t data);
        step(1'b1, 1'b1, addr, data, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic [DW-1:0] data, input logic [NUM_CH-1:0] chg);
        exp_q.push_back(data);
        exp_chg_q.push_back(chg);
    endtask

    task automatic commit(input logic [DW-1:0] data, input logic [NUM_CH-1:0] chg);
        push_exp(data, chg);
        step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset for three edges.
        repeat (3) step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        idle();
        check("reset_dataout", ep_dataout, '0);
        check("reset_changed", DW'(ep_changed), '0);
        check("reset_pending", DW'(ep_pending), '0);
        check("reset_updated", DW'(ep_updated), '0);

        // Two words into channel 0, then commit.
        wr(8'h04, 16'h5678);
        wr(8'h05, 16'h1234);
        idle();
        check("ch0_pending", DW'(ep_pending), DW'(4'b0001));
        check("ch0_held_before_commit", ep_dataout, '0);
        commit(128'h00000000_00000000_00000000_12345678, 4'b0001);
        idle();

        // Write channel 1 low word; output must not move until commit.
        wr(8'h06, 16'hABCD);
        idle();
        check("ch1_pending", DW'(ep_pending), DW'(4'b0010));
        check("ch1_held_before_commit", ep_dataout,
              128'h00000000_00000000_00000000_12345678);
        commit(128'h00000000_00000000_0000ABCD_12345678, 4'b0010);
        idle();
        check("ch1_pending_cleared", DW'(ep_pending), '0);

        // Commit with nothing new written.
        commit(128'h00000000_00000000_0000ABCD_12345678, 4'b0000);
        idle();

        // Write and commit in the same cycle, then a back-to-back commit.
        push_exp(128'h00000000_00000001_0000ABCD_12345678, 4'b0100);
        step(1'b1, 1'b1, 8'h08, 16'h0001, 1'b1, 1'b0);
        commit(128'h00000000_00000001_0000ABCD_12345678, 4'b0000);
        check("same_cycle_pending_clear", DW'(ep_pending), '0);
        idle();

        // Channel 3 upper word plus two writes outside the bank.
        wr(8'h0B, 16'hFFFF);
        wr(8'h0C, 16'h9999);
        wr(8'h03, 16'h7777);
        idle();
        check("ch3_pending_only", DW'(ep_pending), DW'(4'b1000));
        check("ch3_held_before_commit", ep_dataout,
              128'h00000000_00000001_0000ABCD_12345678);
        commit(128'hFFFF0000_00000001_0000ABCD_12345678, 4'b1000);
        idle();

        // Rewriting an identical value sets pending but causes no change.
        wr(8'h04, 16'h5678);
        idle();
        check("same_value_pending", DW'(ep_pending), DW'(4'b0001));
        commit(128'hFFFF0000_00000001_0000ABCD_12345678, 4'b0000);
        idle();

        // Reset asserted during a commit wins; holds are cleared too.
        wr(8'h04, 16'hAAAA);
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        idle();
        check("rst_commit_dataout", ep_dataout, '0);
        check("rst_commit_changed", DW'(ep_changed), '0);
        check("rst_commit_pending", DW'(ep_pending), '0);
        check("rst_commit_updated", DW'(ep_updated), '0);
        commit('0, 4'b0000);
        idle();

`ifdef OK_WIRE_READBACK_EN
        // Readback of a hold register, then an address outside the bank.
        wr(8'h07, 16'hBEEF);
        step(1'b1, 1'b0, 8'h07, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h1F, 16'h0000, 1'b0, 1'b1);
        check("readback_07", DW'(ti_dataout), DW'(16'hBEEF));
        idle();
        check("readback_1f", DW'(ti_dataout), '0);
`endif

        // Let the monitor drain; every pushed commit must have been seen.
        repeat (4) idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_update: %0d commits outstanding, expected 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ok_wire_bank.md
OK_WIRE_BANK -- requirements
Module: ok_wire_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first wire-in endpoint address of the bank.
REQ-002 SHALL have parameter NUM_CH, default 4: number of channels, 1..32.
REQ-003 SHALL have parameter CH_WIDTH, default 32: bits per channel, multiple of 16, 16..64; WORDS = CH_WIDTH/16.
REQ-004 SHALL have port ti_clock  input  1: the one clock; all logic on its rising edge.
REQ-005 SHALL have port ti_reset_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port ti_write  input  1: host write strobe.
REQ-007 SHALL have port ti_addr  input  8: host endpoint address.
REQ-008 SHALL have port ti_datain  input  16: host write data.
REQ-009 SHALL have port ti_wireupdate  input  1: commit strobe for all channels.
REQ-010 SHALL have port ep_dataout  output  NUM_CH*CH_WIDTH: committed values; channel i at [i*CH_WIDTH +: CH_WIDTH].
REQ-011 SHALL have port ep_changed  output  NUM_CH: per-channel one-cycle change pulse.
REQ-012 SHALL have port ep_pending  output  NUM_CH: channel i written since last commit.
REQ-013 SHALL have port ep_updated  output  1: one-cycle pulse per commit.

Function
REQ-014 SHALL map channel i word w (w=0 least significant) to address BASE_ADDR + i*WORDS + w.
REQ-015 SHALL, on ti_write with matching address, load ti_datain into that word's hold register at the next edge; non-matching writes ignored.
REQ-016 SHALL, on ti_wireupdate, copy every hold register to ep_dataout at the same edge, all channels atomically.
REQ-017 SHALL include a same-cycle write in that commit (write-then-commit ordering).
REQ-018 SHALL set ep_pending[i] on any write to channel i and clear it on commit; a same-cycle write and commit leaves it clear.
REQ-019 SHALL assert ep_changed[i] for exactly the cycle after a commit in which channel i's ep_dataout value differed from its previous value.
REQ-020 SHALL assert ep_updated for exactly the cycle after each commit, whether or not any value changed.
REQ-021 SHALL produce consecutive-cycle commits as back-to-back pulses with no lost commit.
REQ-022 SHALL hold ep_dataout constant between commits regardless of write activity.
REQ-023 SHALL stop simulation with an error at elaboration if BASE_ADDR + NUM_CH*WORDS - 1 > 8'h1F or if any parameter is outside its stated range.

Reset
REQ-024 SHALL, with ti_reset_n low at an edge, clear all hold registers, ep_dataout, ep_changed, ep_pending and ep_updated to 0.
REQ-025 SHALL give reset priority over simultaneous write or commit; the first commit after reset compares against 0.

Configuration
REQ-026 SHALL, with OK_WIRE_READBACK_EN defined, add input ti_read (1) and output ti_dataout (16); on ti_read with a bank address, ti_dataout SHALL present that word's hold register the next cycle, else 0.
REQ-027 SHALL, without OK_WIRE_READBACK_EN, omit ti_read, ti_dataout and all readback logic.

Structure
REQ-028 SHALL take the word width (16), address width (8), wire-in range limits (8'h00, 8'h1F) and maximum CH_WIDTH from the shared package ok_wire_pkg.
REQ-029 SHALL instantiate one sub-module, ok_wire_chan, per channel, containing the hold words, output register, pending flag and change compare.

Verification
REQ-030 SHALL cover BASE_ADDR=8'h04, CH_WIDTH=32: writes 8'h04=16'h5678 and 8'h05=16'h1234, then commit -> ch0 ep_dataout=32'h12345678, ep_changed[0] and ep_updated pulse one cycle.
REQ-031 SHALL cover a write to 8'h06 without commit -> ep_pending[1]=1 and ep_dataout unchanged; after commit -> ep_pending[1]=0.
REQ-032 SHALL cover a commit with no new writes -> ep_updated pulses and ep_changed=0.
REQ-033 SHALL cover a write and commit in the same cycle -> the new value appears in ep_dataout and ep_pending stays 0.
REQ-034 SHALL cover ti_reset_n low during a commit -> all outputs 0 at the next edge; a following commit with holds=0 gives ep_changed=0.
REQ-035 SHALL cover OK_WIRE_READBACK_EN: write 16'hBEEF to 8'h07, then ti_read at 8'h07 -> ti_dataout=16'hBEEF one cycle later; ti_read at 8'h1F -> 16'h0000.
